// File: rtl/audio_mixer_if.sv
// DAC-side frame handshake: head sample pair plus valid/ready.
// master drives left/right/valid, slave drives ready.
interface audio_mixer_if;
  logic signed [15:0] left;
  logic signed [15:0] right;
  logic               valid;
  logic               ready;

  modport master (
    output left,
    output right,
    output valid,
    input  ready
  );

  modport slave (
    input  left,
    input  right,
    input  valid,
    output ready
  );
endinterface

// File: rtl/audio_mixer.sv
// Stereo mixer: sample-rate tick, per-channel accumulate, master volume,
// saturation and frame FIFO toward the DAC.
// Ports: clk, rst (sync, active-high), i_samples/i_isMono/i_isRight/
// i_isPlaying per channel, i_masterVolume (128 = unity), o_sampleTick,
// o_dropCount, dac (master: left/right/valid out, ready in).
// Optional peak meters (i_peakClear, o_peakLeft, o_peakRight) are built
// when AUDIO_MIXER_PEAK_EN is defined.
module audio_mixer #(
  parameter int NUM_CHANNELS = 8,
  parameter int CLK_DIV      = 1134,
  parameter int FIFO_DEPTH   = 4
) (
  input  logic                      clk,
  input  logic                      rst,
  input  logic [16*NUM_CHANNELS-1:0] i_samples,
  input  logic [NUM_CHANNELS-1:0]   i_isMono,
  input  logic [NUM_CHANNELS-1:0]   i_isRight,
  input  logic [NUM_CHANNELS-1:0]   i_isPlaying,
  input  logic [7:0]                i_masterVolume,
  output logic                      o_sampleTick,
  output logic [15:0]               o_dropCount,
`ifdef AUDIO_MIXER_PEAK_EN
  input  logic                      i_peakClear,
  output logic [15:0]               o_peakLeft,
  output logic [15:0]               o_peakRight,
`endif
  audio_mixer_if.master             dac
);

  localparam int DW = $clog2(CLK_DIV);
  localparam int IW = (NUM_CHANNELS > 1) ? $clog2(NUM_CHANNELS) : 1;
  localparam int AW = 16 + $clog2(NUM_CHANNELS) + 1;
  localparam int PW = AW + 9;
  localparam int FW = $clog2(FIFO_DEPTH);

  typedef enum logic [2:0] {
    S_IDLE, S_WAIT, S_ACCUM, S_SCALE, S_PUSH
  } state_t;

  state_t              state, state_n;
  logic [DW-1:0]       div;
  logic [IW-1:0]       idx;
  logic signed [AW-1:0] acc_l, acc_r;
  logic signed [15:0]  y_l, y_r;
  logic [15:0]         smp;
  logic signed [AW-1:0] s_ext;
  logic                last_ch;
  logic signed [PW-1:0] prod_l, prod_r;

  logic [31:0]         mem [FIFO_DEPTH];
  logic [FW-1:0]       wr_ptr, rd_ptr, rd_ptr_n;
  logic [FW:0]         count, count_n;
  logic                full, push, pop;
  logic [31:0]         din, head_n;

  function automatic logic [15:0] sat16(input logic signed [PW-1:0] p);
    logic signed [PW-1:0] q;
    q = p >>> 7;
    if (q > $signed(PW'(32767)))
      sat16 = 16'h7FFF;
    else if (q < $signed(PW'(-32768)))
      sat16 = 16'h8000;
    else
      sat16 = q[15:0];
  endfunction

  // Sample-rate divider; the tick is the terminal count itself.
  always_ff @(posedge clk) begin
    if (rst)
      div <= '0;
    else if (div == DW'(CLK_DIV - 1))
      div <= '0;
    else
      div <= div + 1'b1;
  end

  assign o_sampleTick = (div == DW'(CLK_DIV - 1));

  always_comb begin
    smp = '0;
    for (int k = 0; k < NUM_CHANNELS; k++)
      if (idx == IW'(k))
        smp = i_samples[16*k +: 16];
  end

  assign s_ext   = i_isPlaying[idx] ? AW'($signed(smp)) : '0;
  assign last_ch = (idx == IW'(NUM_CHANNELS - 1));
  assign prod_l  = PW'(acc_l) * PW'($signed({1'b0, i_masterVolume}));
  assign prod_r  = PW'(acc_r) * PW'($signed({1'b0, i_masterVolume}));

  always_comb begin
    state_n = state;
    unique case (state)
      S_IDLE:  if (o_sampleTick) state_n = S_WAIT;
      S_WAIT:  state_n = S_ACCUM;
      S_ACCUM: if (last_ch) state_n = S_SCALE;
      S_SCALE: state_n = S_PUSH;
      S_PUSH:  state_n = S_IDLE;
      default: state_n = S_IDLE;
    endcase
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      state <= S_IDLE;
      idx   <= '0;
      acc_l <= '0;
      acc_r <= '0;
      y_l   <= '0;
      y_r   <= '0;
    end else begin
      state <= state_n;
      if (state == S_IDLE && o_sampleTick) begin
        acc_l <= '0;
        acc_r <= '0;
      end
      if (state == S_WAIT)
        idx <= '0;
      if (state == S_ACCUM) begin
        idx <= idx + 1'b1;
        // Mono feeds both sides; stereo picks one side.
        if (i_isMono[idx] || !i_isRight[idx])
          acc_l <= acc_l + s_ext;
        if (i_isMono[idx] || i_isRight[idx])
          acc_r <= acc_r + s_ext;
      end
      if (state == S_SCALE) begin
        y_l <= sat16(prod_l);
        y_r <= sat16(prod_r);
      end
    end
  end

  // Frame FIFO; full is judged on the pre-pop count.
  assign full     = (count == (FW+1)'(FIFO_DEPTH));
  assign push     = (state == S_PUSH) && !full;
  assign pop      = dac.valid && dac.ready;
  assign din      = {y_l, y_r};
  assign rd_ptr_n = pop ? rd_ptr + 1'b1 : rd_ptr;
  assign count_n  = count + (FW+1)'(push) - (FW+1)'(pop);
  // A push that lands on the new head bypasses the memory read.
  assign head_n   = (push && wr_ptr == rd_ptr_n) ? din : mem[rd_ptr_n];

  always_ff @(posedge clk) begin
    if (push)
      mem[wr_ptr] <= din;
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      wr_ptr      <= '0;
      rd_ptr      <= '0;
      count       <= '0;
      dac.valid   <= 1'b0;
      dac.left    <= '0;
      dac.right   <= '0;
      o_dropCount <= '0;
    end else begin
      if (push)
        wr_ptr <= wr_ptr + 1'b1;
      rd_ptr    <= rd_ptr_n;
      count     <= count_n;
      dac.valid <= (count_n != '0);
      if (count_n != '0)
        {dac.left, dac.right} <= head_n;
      if (state == S_PUSH && full && o_dropCount != 16'hFFFF)
        o_dropCount <= o_dropCount + 1'b1;
    end
  end

`ifdef AUDIO_MIXER_PEAK_EN
  function automatic logic [15:0] abs16(input logic signed [15:0] v);
    if (v == 16'sh8000)
      abs16 = 16'h7FFF;
    else if (v < 0)
      abs16 = 16'(-v);
    else
      abs16 = v;
  endfunction

  always_ff @(posedge clk) begin
    if (rst || i_peakClear) begin
      o_peakLeft  <= '0;
      o_peakRight <= '0;
    end else if (state == S_PUSH) begin
      if (abs16(y_l) > o_peakLeft)
        o_peakLeft <= abs16(y_l);
      if (abs16(y_r) > o_peakRight)
        o_peakRight <= abs16(y_r);
    end
  end
`endif

endmodule

// File: tb/tb_audio_mixer.sv
// Bench for audio_mixer: vector table of mixes, tick timing,
// backpressure/drop and mid-frame reset, with a frame scoreboard.
module tb_audio_mixer;
  localparam int NCH   = 4;
  localparam int DIV   = 20;
  localparam int DEPTH = 4;

  logic clk = 1'b0;
  logic rst = 1'b1;
  always #5 clk = ~clk;

  logic [16*NCH-1:0] samples;
  logic [NCH-1:0]    mono, right, play;
  logic [7:0]        vol;
  logic              tick;
  logic [15:0]       drop;
`ifdef AUDIO_MIXER_PEAK_EN
  logic              peak_clear;
  logic [15:0]       peak_l, peak_r;
`endif

  audio_mixer_if dac ();

  audio_mixer #(
    .NUM_CHANNELS(NCH),
    .CLK_DIV(DIV),
    .FIFO_DEPTH(DEPTH)
  ) dut (
    .clk(clk),
    .rst(rst),
    .i_samples(samples),
    .i_isMono(mono),
    .i_isRight(right),
    .i_isPlaying(play),
    .i_masterVolume(vol),
    .o_sampleTick(tick),
    .o_dropCount(drop),
`ifdef AUDIO_MIXER_PEAK_EN
    .i_peakClear(peak_clear),
    .o_peakLeft(peak_l),
    .o_peakRight(peak_r),
`endif
    .dac(dac)
  );

  typedef struct {
    logic [16*NCH-1:0] smp;
    logic [NCH-1:0]    mono;
    logic [NCH-1:0]    right;
    logic [NCH-1:0]    play;
    logic [7:0]        vol;
    logic [15:0]       exp_l;
    logic [15:0]       exp_r;
  } vec_t;

  int total = 0;
  int bad   = 0;
  logic [31:0] sb [$];
  vec_t vecs [10];

  function automatic vec_t mk(
    input logic [15:0] s0, s1, s2, s3,
    input logic [3:0] mo, ri, pl,
    input logic [7:0] v,
    input logic [15:0] el, er
  );
    vec_t t;
    t.smp   = {s3, s2, s1, s0};
    t.mono  = mo;
    t.right = ri;
    t.play  = pl;
    t.vol   = v;
    t.exp_l = el;
    t.exp_r = er;
    return t;
  endfunction

  task automatic check(input string name,
                       input logic [31:0] act,
                       input logic [31:0] req);
    total++;
    if (act !== req) begin
      bad++;
      $display("FAIL %s got=%h required=%h", name, act, req);
    end
  endtask

  // Scoreboard: a frame leaves the DUT at the edge after valid&&ready.
  always @(negedge clk) begin : mon
    logic [31:0] e;
    if (!rst && dac.valid && dac.ready) begin
      if (sb.size() == 0) begin
        total++;
        bad++;
        $display("FAIL unexpected_frame got=%h required=none",
                 {dac.left, dac.right});
      end else begin
        e = sb.pop_front();
        check("frame", {dac.left, dac.right}, e);
      end
    end
  end

  task automatic drive(input vec_t v);
    @(posedge clk);
    #1;
    samples = v.smp;
    mono    = v.mono;
    right   = v.right;
    play    = v.play;
    vol     = v.vol;
  endtask

  task automatic wait_tick(output bit ok);
    ok = 1'b0;
    for (int i = 0; i < 2 * DIV; i++) begin
      @(negedge clk);
      if (tick) begin
        ok = 1'b1;
        break;
      end
    end
    if (!ok) begin
      total++;
      bad++;
      $display("FAIL tick_timeout got=none required=tick");
    end
  endtask

  task automatic run_frame(input vec_t v, input bit keep);
    bit ok;
    drive(v);
    wait_tick(ok);
    if (ok && keep)
      sb.push_back({v.exp_l, v.exp_r});
    repeat (NCH + 5) @(negedge clk);
  endtask

  initial begin
    vec_t z;
    vec_t f;
    bit   ok;
    z = mk(16'h0, 16'h0, 16'h0, 16'h0, 4'b0, 4'b0, 4'b0, 8'd128,
           16'h0, 16'h0);
    samples = '0;
    mono    = '0;
    right   = '0;
    play    = '0;
    vol     = 8'd128;
    dac.ready = 1'b1;
`ifdef AUDIO_MIXER_PEAK_EN
    peak_clear = 1'b0;
`endif

    vecs[0] = mk(16'h1000, 16'h0800, 16'hF000, 16'h1234,
                 4'b0001, 4'b0100, 4'b0111, 8'd128, 16'h1800, 16'h0000);
    vecs[1] = mk(16'h7000, 16'h7000, 16'h7000, 16'h7000,
                 4'b1111, 4'b0000, 4'b1111, 8'd128, 16'h7FFF, 16'h7FFF);
    vecs[2] = mk(16'h9000, 16'h9000, 16'h9000, 16'h9000,
                 4'b1111, 4'b0000, 4'b1111, 8'd128, 16'h8000, 16'h8000);
    vecs[3] = mk(16'h4000, 16'h0, 16'h0, 16'h0,
                 4'b0001, 4'b0000, 4'b0001, 8'd64, 16'h2000, 16'h2000);
    vecs[4] = mk(16'h4000, 16'h0, 16'h0, 16'h0,
                 4'b0001, 4'b0000, 4'b0001, 8'd255, 16'h7F80, 16'h7F80);
    vecs[5] = mk(16'h4000, 16'h0, 16'h0, 16'h0,
                 4'b0001, 4'b0000, 4'b0000, 8'd128, 16'h0000, 16'h0000);
    vecs[6] = mk(16'hFFFF, 16'h0, 16'h0, 16'h0,
                 4'b0001, 4'b0000, 4'b0001, 8'd64, 16'hFFFF, 16'hFFFF);
    vecs[7] = mk(16'h0100, 16'h0100, 16'h0100, 16'h0100,
                 4'b0000, 4'b1111, 4'b1111, 8'd128, 16'h0000, 16'h0400);
    vecs[8] = mk(16'h7000, 16'h0, 16'h0, 16'h0,
                 4'b0001, 4'b0000, 4'b0001, 8'd0, 16'h0000, 16'h0000);
    vecs[9] = mk(16'h0200, 16'hFF00, 16'h0010, 16'h0300,
                 4'b0100, 4'b1000, 4'b1111, 8'd128, 16'h0110, 16'h0310);

    // Tick timing and reset state.
    repeat (3) @(posedge clk);
    #1;
    rst = 1'b0;
    for (int c = 0; c < 70; c++) begin
      @(negedge clk);
      if (c == 0) begin
        check("rst_left", 32'(dac.left), 32'h0);
        check("rst_right", 32'(dac.right), 32'h0);
        check("rst_drop", 32'(drop), 32'h0);
      end
      check("tick_time", 32'(tick),
            32'(c == 19 || c == 39 || c == 59));
      if (c <= 26)
        check("valid_idle", 32'(dac.valid), 32'h0);
      if (tick)
        sb.push_back(32'h0);
    end

    foreach (vecs[i])
      run_frame(vecs[i], 1'b1);

`ifdef AUDIO_MIXER_PEAK_EN
    check("peak_left", 32'(peak_l), 32'h7FFF);
    check("peak_right", 32'(peak_r), 32'h7FFF);
    @(posedge clk);
    #1;
    peak_clear = 1'b1;
    @(posedge clk);
    #1;
    peak_clear = 1'b0;
    @(negedge clk);
    check("peak_clear_l", 32'(peak_l), 32'h0);
    check("peak_clear_r", 32'(peak_r), 32'h0);
`endif

    // Backpressure: four frames stored, three dropped.
    @(posedge clk);
    #1;
    dac.ready = 1'b0;
    for (int k = 0; k < DEPTH + 3; k++) begin
      f = mk(16'((k + 1) * 16'h0100), 16'h0, 16'h0, 16'h0,
             4'b0001, 4'b0000, 4'b0001, 8'd128,
             16'((k + 1) * 16'h0100), 16'((k + 1) * 16'h0100));
      run_frame(f, k < DEPTH);
    end
    check("drop_count", 32'(drop), 32'd3);
    check("full_valid", 32'(dac.valid), 32'h1);
    @(posedge clk);
    #1;
    dac.ready = 1'b1;
    run_frame(z, 1'b1);
    check("drained", 32'(sb.size()), 32'h0);
    check("drop_hold", 32'(drop), 32'd3);

    // Reset in the middle of ACCUM.
    drive(vecs[0]);
    wait_tick(ok);
    repeat (3) @(negedge clk);
    @(posedge clk);
    #1;
    rst = 1'b1;
    @(posedge clk);
    #1;
    rst = 1'b0;
    for (int c = 0; c < 30; c++) begin
      @(negedge clk);
      if (c == 0) begin
        check("rst2_drop", 32'(drop), 32'h0);
        check("rst2_left", 32'(dac.left), 32'h0);
      end
      check("rst2_tick", 32'(tick), 32'(c == DIV - 1));
      if (c <= DIV - 1 + NCH + 3)
        check("rst2_valid", 32'(dac.valid), 32'h0);
      if (tick)
        sb.push_back({vecs[0].exp_l, vecs[0].exp_r});
    end
    check("final_empty", 32'(sb.size()), 32'h0);

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
